// File: rtl/guess_pkg.sv
// Shared types and default constants for the guess-the-sequence game controller.
//   game_state_t : FSM state encoding (ENTER_A is all-zero so reset reads as 0)
//   sym_t        : one stored button symbol (value of the pressed key index)
//   key_to_sym   : lowest-index priority encode of simultaneous key edges
package guess_pkg;

    typedef enum logic [2:0] {
        StEnterA  = 3'd0,
        StEnterB  = 3'd1,
        StCompare = 3'd2,
        StWin     = 3'd3,
        StLose    = 3'd4
    } game_state_t;

    typedef logic [1:0] sym_t;

    localparam int unsigned GUESS_MAX_LEN   = 7;
    localparam int unsigned GUESS_MIN_LEN   = 4;
    localparam int unsigned GUESS_MAX_TURNS = 3;

    // Length counters hold up to 15 symbols.
    localparam int unsigned LEN_W = 4;

    function automatic sym_t key_to_sym(input logic [3:0] k);
        if (k[0]) begin
            return 2'd0;
        end else if (k[1]) begin
            return 2'd1;
        end else if (k[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Bundle of button inputs and status outputs of guess_game_ctrl.
//   master : button/debounce side driving key, enter, new_round; observes status
//   slave  : the controller; consumes buttons, drives state, lengths, turn,
//            match_mask, win, lose, equal, bigger, smaller, guess_done
interface guess_game_ctrl_if
    import guess_pkg::*;
#(
    parameter int unsigned MAX_LEN   = GUESS_MAX_LEN,
    parameter int unsigned MAX_TURNS = GUESS_MAX_TURNS
);
    localparam int unsigned TurnW = $clog2(MAX_TURNS + 1);

    logic [3:0]         key;
    logic               enter;
    logic               new_round;
    game_state_t        state;
    logic [LEN_W-1:0]   len_a;
    logic [LEN_W-1:0]   len_b;
    logic [TurnW-1:0]   turn;
    logic [MAX_LEN-1:0] match_mask;
    logic               win;
    logic               lose;
    logic               equal;
    logic               bigger;
    logic               smaller;
    logic               guess_done;

    modport master (
        output key, enter, new_round,
        input  state, len_a, len_b, turn, match_mask,
        input  win, lose, equal, bigger, smaller, guess_done
    );

    modport slave (
        input  key, enter, new_round,
        output state, len_a, len_b, turn, match_mask,
        output win, lose, equal, bigger, smaller, guess_done
    );

endinterface

// File: rtl/rise_detect.sv
// One-bit rising-edge detector.
//   clk  : clock
//   d    : level input, synchronous to clk
//   rise : high in the cycle where d is 1 and was 0 at the previous edge
// The history register loads d on every edge, reset included, so a level held
// through reset never produces an edge afterwards.
module rise_detect (
    input  logic clk,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        prev_q <= d;
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Sequencer for the two-player guess game: captures player A's secret, then
// up to MAX_TURNS guesses from player B, comparing each and latching results.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : slave side of guess_game_ctrl_if (buttons in, status out)
module guess_game_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned MAX_LEN   = GUESS_MAX_LEN,
    parameter int unsigned MIN_LEN   = GUESS_MIN_LEN,
    parameter int unsigned MAX_TURNS = GUESS_MAX_TURNS
) (
    input logic              clk,
    input logic              reset,
    guess_game_ctrl_if.slave bus
);

    localparam int unsigned      TurnW    = $clog2(MAX_TURNS + 1);
    localparam logic [LEN_W-1:0] MaxLenL  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MinLenL  = LEN_W'(MIN_LEN);
    localparam logic [TurnW-1:0] MaxTurnL = TurnW'(MAX_TURNS);

    // Edge detection on all button inputs.
    logic [3:0] key_rise;
    logic       enter_rise;
    logic       new_round_rise;

    for (genvar g = 0; g < 4; g++) begin : g_key_rise
        rise_detect u_key_rise (
            .clk  (clk),
            .d    (bus.key[g]),
            .rise (key_rise[g])
        );
    end

    rise_detect u_enter_rise (
        .clk  (clk),
        .d    (bus.enter),
        .rise (enter_rise)
    );

    rise_detect u_new_round_rise (
        .clk  (clk),
        .d    (bus.new_round),
        .rise (new_round_rise)
    );

    // State and storage.
    game_state_t        state_q, state_d;
    logic [LEN_W-1:0]   len_a_q, len_a_d;
    logic [LEN_W-1:0]   len_b_q, len_b_d;
    logic [TurnW-1:0]   turn_q, turn_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               equal_q, equal_d;
    logic               bigger_q, bigger_d;
    logic               smaller_q, smaller_d;
    logic               guess_done_q, guess_done_d;
    sym_t               secret_q [MAX_LEN];
    sym_t               secret_d [MAX_LEN];
    sym_t               guess_q  [MAX_LEN];
    sym_t               guess_d  [MAX_LEN];

    // Comparison of the stored sequences.
    logic [MAX_LEN-1:0] cmp_mask;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    always_comb begin
        cmp_mask = '0;
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_a_q));
            cmp_mask[i] = (i < int'(len_a_q)) && (i < int'(len_b_q)) &&
                          (secret_q[i] == guess_q[i]);
        end
        hit = (len_a_q == len_b_q) && (cmp_mask == len_mask);
    end

    logic             key_any;
    sym_t             key_sym;
    logic [LEN_W-1:0] len_a_inc;
    logic [LEN_W-1:0] len_b_inc;
    logic [TurnW-1:0] turn_inc;

    assign key_any   = |key_rise;
    assign key_sym   = key_to_sym(key_rise);
    assign len_a_inc = len_a_q + LEN_W'(1);
    assign len_b_inc = len_b_q + LEN_W'(1);
    assign turn_inc  = turn_q + TurnW'(1);

    always_comb begin
        state_d      = state_q;
        len_a_d      = len_a_q;
        len_b_d      = len_b_q;
        turn_d       = turn_q;
        mask_d       = mask_q;
        win_d        = win_q;
        lose_d       = lose_q;
        equal_d      = equal_q;
        bigger_d     = bigger_q;
        smaller_d    = smaller_q;
        guess_done_d = 1'b0;
        secret_d     = secret_q;
        guess_d      = guess_q;

        case (state_q)
            StEnterA: begin
                // A key edge takes priority; a coincident enter edge is dropped.
                if (key_any && (len_a_q < MaxLenL)) begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        if (i == int'(len_a_q)) secret_d[i] = key_sym;
                    end
                    len_a_d = len_a_inc;
                    if (len_a_inc == MaxLenL) state_d = StEnterB;
                end else if (enter_rise && (len_a_q >= MinLenL)) begin
                    state_d = StEnterB;
                end
            end
            StEnterB: begin
                if (key_any && (len_b_q < MaxLenL)) begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        if (i == int'(len_b_q)) guess_d[i] = key_sym;
                    end
                    len_b_d = len_b_inc;
                    if (len_b_inc == MaxLenL) state_d = StCompare;
                end else if (enter_rise && (len_b_q >= MinLenL)) begin
                    state_d = StCompare;
                end
            end
            StCompare: begin
                mask_d       = cmp_mask;
                equal_d      = (len_b_q == len_a_q);
                bigger_d     = (len_b_q < len_a_q);
                smaller_d    = (len_b_q > len_a_q);
                guess_done_d = 1'b1;
                if (hit) begin
                    win_d   = 1'b1;
                    state_d = StWin;
                end else if (turn_inc == MaxTurnL) begin
                    turn_d  = turn_inc;
                    lose_d  = 1'b1;
                    state_d = StLose;
                end else begin
                    turn_d  = turn_inc;
                    len_b_d = '0;
                    for (int i = 0; i < int'(MAX_LEN); i++) guess_d[i] = '0;
                    state_d = StEnterB;
                end
            end
            StWin, StLose: begin
                if (new_round_rise) begin
                    len_a_d   = '0;
                    len_b_d   = '0;
                    turn_d    = '0;
                    mask_d    = '0;
                    win_d     = 1'b0;
                    lose_d    = 1'b0;
                    equal_d   = 1'b0;
                    bigger_d  = 1'b0;
                    smaller_d = 1'b0;
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        secret_d[i] = '0;
                        guess_d[i]  = '0;
                    end
                    state_d = StEnterA;
                end
            end
            default: state_d = StEnterA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StEnterA;
            len_a_q      <= '0;
            len_b_q      <= '0;
            turn_q       <= '0;
            mask_q       <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            equal_q      <= 1'b0;
            bigger_q     <= 1'b0;
            smaller_q    <= 1'b0;
            guess_done_q <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                secret_q[i] <= '0;
                guess_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            len_a_q      <= len_a_d;
            len_b_q      <= len_b_d;
            turn_q       <= turn_d;
            mask_q       <= mask_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            equal_q      <= equal_d;
            bigger_q     <= bigger_d;
            smaller_q    <= smaller_d;
            guess_done_q <= guess_done_d;
            secret_q     <= secret_d;
            guess_q      <= guess_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.len_a      = len_a_q;
    assign bus.len_b      = len_b_q;
    assign bus.turn       = turn_q;
    assign bus.match_mask = mask_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;
    assign bus.equal      = equal_q;
    assign bus.bigger     = bigger_q;
    assign bus.smaller    = smaller_q;
    assign bus.guess_done = guess_done_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl. Inputs change and outputs are checked
// on the falling edge; the DUT acts on the rising edge in between.
module tb_guess_game_ctrl;
    import guess_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    guess_game_ctrl_if #(.MAX_LEN(7), .MAX_TURNS(3)) bus ();

    guess_game_ctrl #(.MAX_LEN(7), .MIN_LEN(4), .MAX_TURNS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic press_mask(input logic [3:0] m);
        bus.key = m;
        step();
        bus.key = 4'b0000;
        step();
    endtask

    task automatic press(input int idx);
        logic [3:0] m;
        m = 4'b0001 << idx;
        press_mask(m);
    endtask

    task automatic press_enter();
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
    endtask

    task automatic press_new_round();
        bus.new_round = 1'b1;
        step();
        bus.new_round = 1'b0;
        step();
    endtask

    // {win, lose, equal, bigger, smaller, guess_done}
    function automatic logic [31:0] flags();
        return {26'd0, bus.win, bus.lose, bus.equal, bus.bigger, bus.smaller, bus.guess_done};
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'(StEnterA));
        chk({tag, "_len_a"}, 32'(bus.len_a), 32'd0);
        chk({tag, "_len_b"}, 32'(bus.len_b), 32'd0);
        chk({tag, "_turn"}, 32'(bus.turn), 32'd0);
        chk({tag, "_mask"}, 32'(bus.match_mask), 32'd0);
        chk({tag, "_flags"}, flags(), 32'd0);
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        reset         = 1'b0;
        bus.key       = 4'b0010;  // key[1] held through reset
        bus.enter     = 1'b0;
        bus.new_round = 1'b0;
        step();
        step();
        chk_cleared("reset");

        reset = 1'b1;
        step();
        step();
        chk("held_key_len_a", 32'(bus.len_a), 32'd0);
        bus.key = 4'b0000;
        step();

        // Exact match; enter at len_a=3 is ignored.
        press(0);
        press(1);
        press(2);
        chk("len_a_3", 32'(bus.len_a), 32'd3);
        press_enter();
        chk("enter_short_state", 32'(bus.state), 32'(StEnterA));
        chk("enter_short_len", 32'(bus.len_a), 32'd3);
        press(3);
        chk("len_a_4", 32'(bus.len_a), 32'd4);
        press_enter();
        chk("to_enter_b", 32'(bus.state), 32'(StEnterB));
        press(0);
        press(1);
        press(2);
        press(3);
        chk("len_b_4", 32'(bus.len_b), 32'd4);
        press_enter();
        chk("win_flags", flags(), 32'b101001);
        chk("win_mask", 32'(bus.match_mask), 32'h0F);
        chk("win_turn", 32'(bus.turn), 32'd0);
        chk("win_state", 32'(bus.state), 32'(StWin));
        step();
        chk("guess_done_drop", flags(), 32'b101000);
        press(0);
        chk("win_key_ignored", 32'(bus.len_b), 32'd4);
        press_new_round();
        chk_cleared("new_round_win");

        // Three misses.
        for (int k = 0; k < 4; k++) press(0);
        press_enter();
        for (int g = 1; g <= 3; g++) begin
            for (int k = 0; k < 4; k++) press(1);
            press_enter();
            chk("miss_turn", 32'(bus.turn), 32'(g));
            chk("miss_flags", flags(), (g == 3) ? 32'b011001 : 32'b001001);
            chk("miss_mask", 32'(bus.match_mask), 32'd0);
            chk("miss_state", 32'(bus.state),
                (g == 3) ? 32'(StLose) : 32'(StEnterB));
            chk("miss_len_b", 32'(bus.len_b), (g == 3) ? 32'd4 : 32'd0);
        end
        press(2);
        chk("lose_key_ignored", 32'(bus.len_b), 32'd4);
        press_new_round();
        chk_cleared("new_round_lose");

        // Length hints: secret 0,1,2,3,0.
        press(0); press(1); press(2); press(3); press(0);
        press_enter();
        chk("len_a_5", 32'(bus.len_a), 32'd5);
        press(0); press(1); press(2); press(3);
        press_enter();
        chk("bigger_flags", flags(), 32'b000101);
        chk("bigger_mask", 32'(bus.match_mask), 32'h0F);
        chk("bigger_turn", 32'(bus.turn), 32'd1);
        press(0); press(1); press(2); press(3); press(0); press(1);
        press_enter();
        chk("smaller_flags", flags(), 32'b000011);
        chk("smaller_mask", 32'(bus.match_mask), 32'h1F);
        chk("smaller_turn", 32'(bus.turn), 32'd2);
        chk("smaller_state", 32'(bus.state), 32'(StEnterB));
        press(0); press(1); press(2); press(3); press(0);
        press_enter();
        chk("hint_win_flags", flags(), 32'b101001);
        chk("hint_win_turn", 32'(bus.turn), 32'd2);
        press_new_round();

        // Simultaneous key[0]+key[2] stores 0; seven keys auto-advance.
        press_mask(4'b0101);
        chk("multi_key_len", 32'(bus.len_a), 32'd1);
        press(1); press(2); press(3); press(0); press(1); press(2);
        chk("auto_a_len", 32'(bus.len_a), 32'd7);
        chk("auto_a_state", 32'(bus.state), 32'(StEnterB));
        press(0); press(1); press(2); press(3); press(0); press(1); press(3);
        chk("auto_b_flags", flags(), 32'b001001);
        chk("auto_b_mask", 32'(bus.match_mask), 32'h3F);
        chk("auto_b_turn", 32'(bus.turn), 32'd1);
        chk("auto_b_state", 32'(bus.state), 32'(StEnterB));

        // Reset while in COMPARE.
        for (int k = 0; k < 4; k++) press(0);
        bus.enter = 1'b1;
        step();
        chk("in_compare", 32'(bus.state), 32'(StCompare));
        bus.enter = 1'b0;
        reset     = 1'b0;
        step();
        chk_cleared("reset_compare");
        reset = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
